// File: rtl/dense_row_sched_pkg.sv
// Shared definitions for the dense-layer row scheduler: FSM encoding and a
// width helper used for counter and index sizing.
package dense_row_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  // Bits needed to hold values 0..value-1; never returns less than 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/dense_row_sched_buf.sv
// Single-entry row buffer with valid/ready upstream handshake; the scheduler
// drains it with take and can stall new rows with block.
module dense_row_buf #(
  parameter int ROW_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             s_valid,
  input  logic [ROW_W-1:0] s_data,
  input  logic             block,
  input  logic             take,
  output logic             s_ready,
  output logic             full,
  output logic [ROW_W-1:0] data,
  output logic             full_next,
  output logic [ROW_W-1:0] data_next
);

  logic             full_reg;
  logic [ROW_W-1:0] data_reg;
  logic             alive_reg;
  logic             load;

  // alive_reg keeps s_ready low while reset is held and for no longer
  assign s_ready   = alive_reg & ~full_reg & ~block;
  assign load      = s_valid & s_ready;
  assign full      = full_reg;
  assign data      = data_reg;
  assign full_next = full_reg | load;
  assign data_next = load ? s_data : data_reg;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      full_reg  <= 1'b0;
      data_reg  <= '0;
      alive_reg <= 1'b0;
    end else begin
      alive_reg <= 1'b1;
      if (take) full_reg <= 1'b0;
      if (load) begin
        full_reg <= 1'b1;
        data_reg <= s_data;
      end
    end
  end

endmodule

// File: rtl/dense_row_sched.sv
// Row scheduler for a dense-layer datapath: issues buffered rows one per
// datapath run, then drains B neuron results per frame of H rows.
module dense_row_sched
  import dense_row_sched_pkg::*;
#(
  parameter int H          = 3,
  parameter int W          = 3,
  parameter int D          = 12,
  parameter int B          = 64,
  parameter int DATA_WIDTH = 8,
  parameter int RUN_CYCLES = 2*B+2
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      s_valid,
  input  logic [W*D*DATA_WIDTH-1:0] s_data,
  output logic                      s_ready,
  output logic                      dp_valid_i,
  output logic [W*D*DATA_WIDTH-1:0] dp_data_i,
  input  logic                      dp_valid_o,
  input  logic [DATA_WIDTH-1:0]     dp_data_o,
  output logic                      m_valid,
  output logic [DATA_WIDTH-1:0]     m_data,
  output logic [clog2(B)-1:0]       m_idx,
  output logic                      m_last,
  output logic                      busy,
  output logic                      frame_done,
  output logic                      err
);

  localparam int ROW_W  = W*D*DATA_WIDTH;
  localparam int IDX_W  = clog2(B);
  localparam int FCNT_W = clog2(B+1);
  localparam int ROWC_W = clog2(H);
  localparam int RUN_W  = clog2(RUN_CYCLES+1);

  state_t              state_reg;
  logic [ROWC_W-1:0]   row_cnt_reg;
  logic [RUN_W-1:0]    run_cnt_reg;
  logic [IDX_W-1:0]    out_cnt_reg;
  logic [FCNT_W-1:0]   frame_out_cnt_reg;
  logic                dp_valid_i_reg;
  logic [ROW_W-1:0]    dp_data_i_reg;
  logic                m_valid_reg;
  logic [DATA_WIDTH-1:0] m_data_reg;
  logic [IDX_W-1:0]    m_idx_reg;
  logic                m_last_reg;
  logic                frame_done_reg;
  logic                err_reg;

  logic                buf_full;
  logic                buf_full_next;
  logic [ROW_W-1:0]    buf_data;
  logic [ROW_W-1:0]    buf_data_next;
  logic                in_window;
  logic                strobe_ok;

  dense_row_buf #(
    .ROW_W (ROW_W)
  ) u_buf (
    .clk       (clk),
    .rstn      (rstn),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .block     (state_reg == ST_DRAIN),
    .take      (state_reg == ST_ISSUE),
    .s_ready   (s_ready),
    .full      (buf_full),
    .data      (buf_data),
    .full_next (buf_full_next),
    .data_next (buf_data_next)
  );

  // Results are only legal while the final row of a frame is computing or draining
  assign in_window = ((state_reg == ST_RUN) && (row_cnt_reg == ROWC_W'(H-1)))
                   || (state_reg == ST_DRAIN);
  assign strobe_ok = in_window && (frame_out_cnt_reg != FCNT_W'(B));

  assign dp_valid_i = dp_valid_i_reg;
  assign dp_data_i  = dp_data_i_reg;
  assign m_valid    = m_valid_reg;
  assign m_data     = m_data_reg;
  assign m_idx      = m_idx_reg;
  assign m_last     = m_last_reg;
  assign frame_done = frame_done_reg;
  assign err        = err_reg;
  assign busy       = !((state_reg == ST_IDLE) && !buf_full && (row_cnt_reg == '0));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg         <= ST_IDLE;
      row_cnt_reg       <= '0;
      run_cnt_reg       <= '0;
      out_cnt_reg       <= '0;
      frame_out_cnt_reg <= '0;
      dp_valid_i_reg    <= 1'b0;
      dp_data_i_reg     <= '0;
      m_valid_reg       <= 1'b0;
      m_data_reg        <= '0;
      m_idx_reg         <= '0;
      m_last_reg        <= 1'b0;
      frame_done_reg    <= 1'b0;
      err_reg           <= 1'b0;
    end else begin
      dp_valid_i_reg <= 1'b0;
      frame_done_reg <= 1'b0;
      m_valid_reg    <= dp_valid_o;
      m_last_reg     <= dp_valid_o && (out_cnt_reg == IDX_W'(B-1));
      if (dp_valid_o) begin
        m_data_reg  <= dp_data_o;
        m_idx_reg   <= out_cnt_reg;
        out_cnt_reg <= (out_cnt_reg == IDX_W'(B-1)) ? '0 : out_cnt_reg + 1'b1;
        if (strobe_ok) frame_out_cnt_reg <= frame_out_cnt_reg + 1'b1;
        else           err_reg <= 1'b1;
      end

      case (state_reg)
        ST_IDLE: begin
          if (buf_full) begin
            state_reg      <= ST_ISSUE;
            dp_valid_i_reg <= 1'b1;
            dp_data_i_reg  <= buf_data;
          end
        end
        ST_ISSUE: begin
          run_cnt_reg <= RUN_W'(RUN_CYCLES-1);
          state_reg   <= ST_RUN;
        end
        ST_RUN: begin
          // ISSUE is the first busy cycle, so the run ends as the count hits 0
          run_cnt_reg <= run_cnt_reg - 1'b1;
          if (run_cnt_reg == RUN_W'(1)) begin
            if (row_cnt_reg == ROWC_W'(H-1)) begin
              state_reg <= ST_DRAIN;
            end else begin
              row_cnt_reg <= row_cnt_reg + 1'b1;
              if (buf_full_next) begin
                state_reg      <= ST_ISSUE;
                dp_valid_i_reg <= 1'b1;
                dp_data_i_reg  <= buf_data_next;
              end else begin
                state_reg <= ST_IDLE;
              end
            end
          end
        end
        ST_DRAIN: begin
          if (frame_out_cnt_reg == FCNT_W'(B)) begin
            frame_done_reg    <= 1'b1;
            row_cnt_reg       <= '0;
            frame_out_cnt_reg <= '0;
            state_reg         <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dense_row_sched.sv
// Self-checking bench for dense_row_sched with a behavioural dense datapath
// that emits B results, spaced two cycles apart, after the last row of a frame.
module tb_dense_row_sched;

  localparam int H     = 3;
  localparam int W     = 3;
  localparam int D     = 12;
  localparam int B     = 4;
  localparam int DW    = 8;
  localparam int RC    = 10;
  localparam int ROW_W = W*D*DW;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             s_valid = 1'b0;
  logic [ROW_W-1:0] s_data = '0;
  logic             s_ready;
  logic             dp_valid_i;
  logic [ROW_W-1:0] dp_data_i;
  logic             dp_valid_o;
  logic [DW-1:0]    dp_data_o;
  logic             m_valid;
  logic [DW-1:0]    m_data;
  logic [1:0]       m_idx;
  logic             m_last;
  logic             busy;
  logic             frame_done;
  logic             err;

  logic             dpo_valid = 1'b0;
  logic [DW-1:0]    dpo_data = '0;
  logic             force_v = 1'b0;
  logic [DW-1:0]    force_d = '0;

  assign dp_valid_o = dpo_valid | force_v;
  assign dp_data_o  = force_v ? force_d : dpo_data;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  dense_row_sched #(
    .H(H), .W(W), .D(D), .B(B), .DATA_WIDTH(DW), .RUN_CYCLES(RC)
  ) dut (
    .clk(clk), .rstn(rstn),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .dp_valid_i(dp_valid_i), .dp_data_i(dp_data_i),
    .dp_valid_o(dp_valid_o), .dp_data_o(dp_data_o),
    .m_valid(m_valid), .m_data(m_data), .m_idx(m_idx), .m_last(m_last),
    .busy(busy), .frame_done(frame_done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int row_sum(input logic [ROW_W-1:0] r);
    int s;
    s = 0;
    for (int i = 0; i < W*D; i++) s += int'(r[i*DW +: DW]);
    return s;
  endfunction

  // Neuron j of a frame is (sum of all frame bytes)*(j+1)+j, modulo 256
  function automatic logic [DW-1:0] exp_out(input int fsum, input int j);
    return DW'((fsum * (j + 1) + j) % 256);
  endfunction

  function automatic logic [ROW_W-1:0] rand_row();
    logic [ROW_W-1:0] r;
    for (int i = 0; i < ROW_W/32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  // Behavioural datapath: accumulates H rows, then streams B results
  int dp_rows = 0, dp_acc = 0, dp_fsum = 0, dp_k = 0, dp_timer = 0;
  bit dp_pend = 1'b0;
  always @(posedge clk) begin
    dpo_valid <= 1'b0;
    if (!rstn) begin
      dp_rows = 0; dp_acc = 0; dp_pend = 1'b0; dp_k = 0; dp_timer = 0;
    end else begin
      if (dp_pend) begin
        if (dp_timer == 0) begin
          dpo_valid <= 1'b1;
          dpo_data  <= DW'((dp_fsum * (dp_k + 1) + dp_k) & 255);
          dp_k++;
          if (dp_k == B) dp_pend = 1'b0;
          else dp_timer = 1;
        end else begin
          dp_timer--;
        end
      end
      if (dp_valid_i) begin
        dp_acc += row_sum(dp_data_i);
        if (dp_rows == H-1) begin
          dp_fsum = dp_acc; dp_acc = 0; dp_rows = 0;
          dp_pend = 1'b1; dp_timer = 1; dp_k = 0;
        end else begin
          dp_rows++;
        end
      end
    end
  end

  int               hs_q[$];
  int               iss_q[$];
  logic [ROW_W-1:0] issd_q[$];
  int               mv_q[$];
  logic [DW-1:0]    mvd_q[$];
  int               mvi_q[$];
  bit               mvl_q[$];
  int               fd_q[$];
  bit               busy_at[int];

  always @(negedge clk) begin
    busy_at[cyc] = busy;
    if (s_valid && s_ready) hs_q.push_back(cyc);
    if (dp_valid_i) begin
      iss_q.push_back(cyc);
      issd_q.push_back(dp_data_i);
    end
    if (m_valid) begin
      mv_q.push_back(cyc);
      mvd_q.push_back(m_data);
      mvi_q.push_back(int'(m_idx));
      mvl_q.push_back(m_last);
    end
    if (frame_done) fd_q.push_back(cyc);
  end

  task automatic clear_logs();
    hs_q.delete(); iss_q.delete(); issd_q.delete();
    mv_q.delete(); mvd_q.delete(); mvi_q.delete(); mvl_q.delete();
    fd_q.delete(); busy_at.delete();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rstn = 1'b0; s_valid = 1'b0; force_v = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk); #1;
    clear_logs();
  endtask

  task automatic push_row(input logic [ROW_W-1:0] d);
    int t;
    s_valid = 1'b1; s_data = d; t = 0;
    @(negedge clk);
    while (!s_ready && t < 300) begin @(negedge clk); t++; end
    compared++;
    if (!s_ready) begin
      mismatched++;
      $display("FAIL push_timeout: s_ready=%b after %0d cycles, required 1", s_ready, t);
    end else begin
      $display("row sum=%0d accepted at cycle %0d", row_sum(d), cyc);
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic wait_iss(input int n);
    int t;
    t = 0;
    while (iss_q.size() < n && t < 200) begin @(negedge clk); t++; end
  endtask

  task automatic wait_fd(input int n);
    int t;
    t = 0;
    while (fd_q.size() < n && t < 600) begin @(negedge clk); t++; end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [8:0] ctl;
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    ctl = {s_ready, dp_valid_i, m_valid, m_last, m_idx, frame_done, busy, err};
    compared++;
    if (ctl !== 9'b0) begin
      mismatched++;
      $display("FAIL reset_ctl: {rdy,dpv,mv,last,idx,fd,busy,err}=%b, required 000000000", ctl);
    end
    compared++;
    if (dp_data_i !== '0) begin
      mismatched++;
      $display("FAIL reset_dp_data: got %h, required 0", dp_data_i);
    end
    compared++;
    if (m_data !== '0) begin
      mismatched++;
      $display("FAIL reset_m_data: got %h, required 0", m_data);
    end
    rstn = 1'b1;
    @(posedge clk); #1;
    compared++;
    if (s_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_ready_after: got %b, required 1", s_ready);
    end
    clear_logs();
  endtask

  task automatic test_back_to_back();
    logic [ROW_W-1:0] rows[3];
    int fsum;
    do_reset();
    fsum = 0;
    for (int i = 0; i < 3; i++) begin
      rows[i] = rand_row();
      fsum += row_sum(rows[i]);
      push_row(rows[i]);
    end
    wait_fd(1);
    compared++;
    if (iss_q.size() != 3 || hs_q.size() != 3) begin
      mismatched++;
      $display("FAIL b2b_counts: issues=%0d handshakes=%0d, required 3/3", iss_q.size(), hs_q.size());
      return;
    end
    compared++;
    if (iss_q[0] - hs_q[0] != 2 || iss_q[1] - hs_q[0] != 2 + RC || iss_q[2] - hs_q[0] != 2 + 2*RC) begin
      mismatched++;
      $display("FAIL b2b_issue_cycles: rel %0d,%0d,%0d, required 2,%0d,%0d",
               iss_q[0]-hs_q[0], iss_q[1]-hs_q[0], iss_q[2]-hs_q[0], 2+RC, 2+2*RC);
    end
    compared++;
    if (hs_q[1] != iss_q[0] + 1 || hs_q[2] != iss_q[1] + 1) begin
      mismatched++;
      $display("FAIL b2b_prefetch_ready: hs %0d,%0d, required %0d,%0d",
               hs_q[1], hs_q[2], iss_q[0]+1, iss_q[1]+1);
    end
    for (int i = 0; i < 3; i++) begin
      compared++;
      if (issd_q[i] !== rows[i]) begin
        mismatched++;
        $display("FAIL b2b_dp_data row%0d: got sum %0d, required sum %0d", i, row_sum(issd_q[i]), row_sum(rows[i]));
      end
    end
    compared++;
    if (mv_q.size() != B || fd_q.size() != 1) begin
      mismatched++;
      $display("FAIL b2b_out_counts: m_valid=%0d frame_done=%0d, required %0d/1", mv_q.size(), fd_q.size(), B);
      return;
    end
    for (int j = 0; j < B; j++) begin
      compared++;
      if (mvi_q[j] != j || mvl_q[j] != (j == B-1) || mvd_q[j] !== exp_out(fsum, j)) begin
        mismatched++;
        $display("FAIL b2b_out%0d: idx=%0d last=%0b data=%h, required idx=%0d last=%0b data=%h",
                 j, mvi_q[j], mvl_q[j], mvd_q[j], j, (j == B-1), exp_out(fsum, j));
      end
    end
    compared++;
    if (fd_q[0] != mv_q[B-1] + 1 || err !== 1'b0) begin
      mismatched++;
      $display("FAIL b2b_frame_done: fd cycle=%0d err=%b, required cycle %0d err 0", fd_q[0], err, mv_q[B-1]+1);
    end
  endtask

  task automatic test_gapped_rows();
    int lows;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      push_row(rand_row());
      repeat (15) @(posedge clk);
      #1;
    end
    wait_fd(1);
    compared++;
    if (iss_q.size() != 3 || hs_q.size() != 3 || fd_q.size() != 1) begin
      mismatched++;
      $display("FAIL gap_counts: issues=%0d hs=%0d fd=%0d, required 3/3/1", iss_q.size(), hs_q.size(), fd_q.size());
      return;
    end
    for (int i = 0; i < 3; i++) begin
      compared++;
      if (iss_q[i] - hs_q[i] != 2) begin
        mismatched++;
        $display("FAIL gap_latency row%0d: got %0d cycles, required 2", i, iss_q[i] - hs_q[i]);
      end
    end
    lows = 0;
    for (int c = hs_q[0] + 1; c < fd_q[0]; c++) if (!busy_at[c]) lows++;
    compared++;
    if (lows != 0 || busy_at[fd_q[0]] != 1'b0 || busy_at[hs_q[0]] != 1'b0) begin
      mismatched++;
      $display("FAIL gap_busy: low cycles in frame=%0d busy@hs=%0b busy@fd=%0b, required 0/0/0",
               lows, busy_at[hs_q[0]], busy_at[fd_q[0]]);
    end
  endtask

  task automatic test_run_end_handshake();
    logic [ROW_W-1:0] r1;
    int i0;
    do_reset();
    push_row(rand_row());
    wait_iss(1);
    compared++;
    if (iss_q.size() < 1) begin
      mismatched++;
      $display("FAIL rend_issue0: got %0d issues, required 1", iss_q.size());
      return;
    end
    i0 = iss_q[0];
    while (cyc < i0 + RC - 1) begin @(posedge clk); #1; end
    r1 = rand_row();
    push_row(r1);
    push_row(rand_row());
    wait_fd(1);
    compared++;
    if (hs_q.size() != 3 || iss_q.size() != 3) begin
      mismatched++;
      $display("FAIL rend_counts: hs=%0d issues=%0d, required 3/3", hs_q.size(), iss_q.size());
      return;
    end
    compared++;
    if (hs_q[1] != i0 + RC - 1 || iss_q[1] != hs_q[1] + 1 || issd_q[1] !== r1) begin
      mismatched++;
      $display("FAIL rend_issue1: hs=%0d issue=%0d sum=%0d, required hs=%0d issue=%0d sum=%0d",
               hs_q[1], iss_q[1], row_sum(issd_q[1]), i0+RC-1, i0+RC, row_sum(r1));
    end
    compared++;
    if (fd_q.size() != 1 || err !== 1'b0) begin
      mismatched++;
      $display("FAIL rend_frame: fd=%0d err=%b, required 1/0", fd_q.size(), err);
    end
  endtask

  task automatic test_err_forced();
    int i0;
    do_reset();
    push_row(rand_row());
    wait_iss(1);
    compared++;
    if (iss_q.size() < 1) begin
      mismatched++;
      $display("FAIL err_issue0: got %0d issues, required 1", iss_q.size());
      return;
    end
    i0 = iss_q[0];
    while (cyc < i0 + 3) begin @(posedge clk); #1; end
    force_d = DW'($urandom_range(1, 255));
    force_v = 1'b1;
    @(posedge clk); #1;
    force_v = 1'b0;
    compared++;
    if (m_valid !== 1'b1 || m_data !== force_d || err !== 1'b1) begin
      mismatched++;
      $display("FAIL err_forced: m_valid=%b m_data=%h err=%b, required 1 %h 1", m_valid, m_data, err, force_d);
    end
    push_row(rand_row());
    push_row(rand_row());
    wait_fd(1);
    compared++;
    if (err !== 1'b1 || fd_q.size() != 1) begin
      mismatched++;
      $display("FAIL err_sticky: err=%b fd=%0d, required 1/1", err, fd_q.size());
    end
    do_reset();
    compared++;
    if (err !== 1'b0) begin
      mismatched++;
      $display("FAIL err_cleared: got %b, required 0", err);
    end
  endtask

  task automatic test_mid_reset();
    logic [ROW_W-1:0] rows[3];
    logic [8:0] ctl;
    int fsum, i1;
    do_reset();
    push_row(rand_row());
    push_row(rand_row());
    wait_iss(2);
    compared++;
    if (iss_q.size() < 2) begin
      mismatched++;
      $display("FAIL mrst_issue1: got %0d issues, required 2", iss_q.size());
      return;
    end
    i1 = iss_q[1];
    while (cyc < i1 + 3) begin @(posedge clk); #1; end
    rstn = 1'b0;
    @(posedge clk); #1;
    ctl = {s_ready, dp_valid_i, m_valid, m_last, m_idx, frame_done, busy, err};
    compared++;
    if (ctl !== 9'b0 || dp_data_i !== '0 || m_data !== '0) begin
      mismatched++;
      $display("FAIL mrst_outputs: ctl=%b dp_data_zero=%0b m_data=%h, required 000000000 1 00",
               ctl, (dp_data_i == '0), m_data);
    end
    rstn = 1'b1;
    clear_logs();
    repeat (40) @(posedge clk);
    #1;
    compared++;
    if (fd_q.size() != 0 || mv_q.size() != 0) begin
      mismatched++;
      $display("FAIL mrst_abandon: fd=%0d m_valid=%0d, required 0/0", fd_q.size(), mv_q.size());
    end
    fsum = 0;
    for (int i = 0; i < 3; i++) begin
      rows[i] = rand_row();
      fsum += row_sum(rows[i]);
      push_row(rows[i]);
    end
    wait_fd(1);
    compared++;
    if (mv_q.size() != B || fd_q.size() != 1 || err !== 1'b0) begin
      mismatched++;
      $display("FAIL mrst_frame: m_valid=%0d fd=%0d err=%b, required %0d/1/0", mv_q.size(), fd_q.size(), err, B);
      return;
    end
    for (int j = 0; j < B; j++) begin
      compared++;
      if (mvi_q[j] != j || mvl_q[j] != (j == B-1) || mvd_q[j] !== exp_out(fsum, j)) begin
        mismatched++;
        $display("FAIL mrst_out%0d: idx=%0d last=%0b data=%h, required idx=%0d last=%0b data=%h",
                 j, mvi_q[j], mvl_q[j], mvd_q[j], j, (j == B-1), exp_out(fsum, j));
      end
    end
  endtask

  task automatic test_two_frames();
    int fsum[2];
    logic [ROW_W-1:0] r;
    do_reset();
    fsum[0] = 0; fsum[1] = 0;
    for (int i = 0; i < 2*H; i++) begin
      r = rand_row();
      fsum[i / H] += row_sum(r);
      push_row(r);
    end
    wait_fd(2);
    compared++;
    if (mv_q.size() != 2*B || fd_q.size() != 2) begin
      mismatched++;
      $display("FAIL two_counts: m_valid=%0d fd=%0d, required %0d/2", mv_q.size(), fd_q.size(), 2*B);
      return;
    end
    for (int k = 0; k < 2*B; k++) begin
      compared++;
      if (mvi_q[k] != k % B || mvl_q[k] != (k % B == B-1) || mvd_q[k] !== exp_out(fsum[k / B], k % B)) begin
        mismatched++;
        $display("FAIL two_out%0d: idx=%0d last=%0b data=%h, required idx=%0d last=%0b data=%h",
                 k, mvi_q[k], mvl_q[k], mvd_q[k], k % B, (k % B == B-1), exp_out(fsum[k / B], k % B));
      end
    end
    compared++;
    if (fd_q[1] != mv_q[2*B-1] + 1 || err !== 1'b0) begin
      mismatched++;
      $display("FAIL two_frame_done: fd2=%0d err=%b, required %0d/0", fd_q[1], err, mv_q[2*B-1]+1);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_gapped_rows();
    test_run_end_handshake();
    test_err_forced();
    test_mid_reset();
    test_two_frames();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d, required completion", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dense_row_sched.md
DENSE_ROW_SCHED -- requirements
Module: dense_row_sched

Interface
REQ-001 SHALL have parameters: H, 3, rows per frame; W, 3, row width; D, 12, input depth; B, 64, output neurons; DATA_WIDTH, 8, element width; RUN_CYCLES, 2*B+2, datapath busy cycles per row.
REQ-002 SHALL have one clock and synchronous active-low reset: clk input 1 system clock; rstn input 1 synchronous active-low reset.
REQ-003 SHALL have: s_valid input 1 upstream row valid; s_data input W*D*DATA_WIDTH row data; s_ready output 1 row accepted when s_valid&s_ready.
REQ-004 SHALL have: dp_valid_i output 1 one-cycle issue pulse to dense datapath; dp_data_i output W*D*DATA_WIDTH held row data.
REQ-005 SHALL have: dp_valid_o input 1 datapath result strobe; dp_data_o input DATA_WIDTH datapath result.
REQ-006 SHALL have: m_valid output 1 result valid; m_data output DATA_WIDTH result; m_idx output clog2(B) neuron index; m_last output 1 final neuron of frame.
REQ-007 SHALL have: busy output 1 frame in progress; frame_done output 1 one-cycle pulse; err output 1 sticky protocol error.

Function
REQ-008 SHALL hold one row in a buffer register; s_ready=1 iff buffer empty and state is not DRAIN.
REQ-009 SHALL implement states IDLE, ISSUE, RUN, DRAIN.
REQ-010 IDLE: on buffer full go to ISSUE; busy=0 only when IDLE, buffer empty and row count 0.
REQ-011 ISSUE: assert dp_valid_i for exactly one cycle with dp_data_i=buffer; mark buffer empty in same cycle; load run counter with RUN_CYCLES-1; go to RUN.
REQ-012 RUN: decrement run counter each cycle; at 0, if row count==H-1 go DRAIN, else increment row count and go IDLE (or ISSUE directly if buffer full).
REQ-013 A new row SHALL be accepted during RUN (prefetch) but SHALL NOT be issued before RUN completes.
REQ-014 DRAIN: wait until output count reaches B; then pulse frame_done, clear row count, go IDLE.
REQ-015 Each dp_valid_o SHALL produce m_valid one cycle later with m_data=dp_data_o, m_idx=output count, m_last=(output count==B-1).
REQ-016 Output count SHALL increment per dp_valid_o, wrap to 0 after B-1; no downstream backpressure exists.
REQ-017 dp_valid_o outside final-row RUN/DRAIN, or more than B strobes per frame, SHALL set err and be forwarded unchanged.
REQ-018 dp_data_i SHALL remain stable from ISSUE until next ISSUE.
REQ-019 Issue latency: row accepted in IDLE with datapath idle -> dp_valid_i exactly 2 cycles after handshake cycle.
REQ-020 Simultaneous s_valid handshake and RUN end SHALL both take effect; new row issues next cycle.

Reset
REQ-021 On rstn=0 at clk edge: state IDLE, buffer empty, all counters 0, s_ready=0 during reset then 1, dp_valid_i=0, m_valid=0, m_last=0, m_idx=0, frame_done=0, busy=0, err=0, dp_data_i=0, m_data=0.
REQ-022 Reset mid-frame SHALL abandon the frame with no frame_done; the datapath is reset by the same rstn.

Structure
REQ-023 State encoding and clog2 function SHALL live in the shared package; H, W, D, B, DATA_WIDTH remain module parameters.
REQ-024 Row buffer with valid/ready SHALL be one sub-module, dense_row_buf; FSM and counters in the top.

Verification (bench with H=3, W=3, D=12, B=4, RUN_CYCLES=10, connected to real datapath)
REQ-025 Three back-to-back rows at cycle 0,1,2 -> dp_valid_i at cycles 2, 12, 22; s_ready low while buffer holds prefetched row.
REQ-026 Full frame -> exactly 4 m_valid, m_idx 0,1,2,3, m_last only on idx 3, frame_done one cycle after last m_valid, err=0.
REQ-027 Rows with 15-cycle gaps -> each dp_valid_i 2 cycles after its handshake; busy stays 1 from first row until frame_done.
REQ-028 Forced dp_valid_o during row 0 RUN -> err=1 and sticky until rstn.
REQ-029 rstn low for 1 cycle during row 1 RUN -> all outputs at reset values; next frame completes with m_idx restarting at 0.
REQ-030 Two consecutive frames without idle gap -> 8 m_valid total, two frame_done pulses, m_idx wraps 3->0.
